seg7_bus_reader: RTL

- Self-check monitor for the clock's multiplexed 7-segment display bus.
- Samples the active-low segment lines and active-low digit anodes, and inverts the BCD-to-segment encoding back to BCD per digit.
- Filters scan transients and flags illegal patterns.
- Gives the verification and BIST logic a readback of the displayed time that is independent of the display path.

---
 rtl/seg7_bus_reader.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_bus_reader.sv
// -----------------------------------------------------------------------------
// seg7_bus_reader
//
// Passive monitor for a multiplexed, active-low 7-segment display bus. It
// watches the segment lines and digit anodes, waits for each anode dwell to
// settle, and converts the segment pattern back to a BCD digit. A digit is
// confirmed only after the same value has been seen on several consecutive
// scans. This gives a readback of the displayed time that does not depend on
// the logic that drives the display.
//
// Optional feature:
//   SEG7_HEX_DECODE_EN - when defined, the patterns for A, b, C, d, E and F
//                        decode to 10..15 and count as numeric. When not
//                        defined, those patterns are illegal.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   seg_in       segment lines, active low, bit6 = a ... bit0 = g
//   an_in        digit anodes, active low, exactly one low selects a digit
//   bcd_out      confirmed digit values, digit i at [4i+3:4i]
//   digit_valid  digit i currently holds a confirmed numeric value
//   frame_done   one-cycle pulse after the last digit's sample when all valid
//   pattern_err  one-cycle pulse when an illegal segment pattern is sampled
//   err_digit    one-hot index of the last digit that produced an error
// -----------------------------------------------------------------------------
module seg7_bus_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int STABLE_COUNT  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    pattern_err,
    output logic [NUM_DIGITS-1:0]   err_digit
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int STB_W = $clog2(STABLE_COUNT + 1);

    localparam logic [SET_W-1:0]      SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [STB_W-1:0]      STABLE_MAX  = STB_W'(STABLE_COUNT);
    localparam logic [STB_W-1:0]      STABLE_ONE  = STB_W'(1);
    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT_0   = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        SEG_NUM,
        SEG_BLANK,
        SEG_ILLEGAL
    } seg_kind_t;

    typedef struct packed {
        seg_kind_t  kind;
        logic [3:0] value;
    } seg_dec_t;

    // Inverse of the display's BCD-to-segment table (active-low abcdefg).
    function automatic seg_dec_t decode_seg(input logic [6:0] seg);
        seg_dec_t d;
        d.kind  = SEG_NUM;
        d.value = 4'd0;
        case (seg)
            7'b0000001: d.value = 4'd0;
            7'b1001111: d.value = 4'd1;
            7'b0010010: d.value = 4'd2;
            7'b0000110: d.value = 4'd3;
            7'b1001100: d.value = 4'd4;
            7'b0100100: d.value = 4'd5;
            7'b0100000: d.value = 4'd6;
            7'b0001111: d.value = 4'd7;
            7'b0000000: d.value = 4'd8;
            7'b0000100: d.value = 4'd9;
            7'b1111111: d.kind  = SEG_BLANK;
`ifdef SEG7_HEX_DECODE_EN
            7'b0001000: d.value = 4'hA;
            7'b1100000: d.value = 4'hB;
            7'b0110001: d.value = 4'hC;
            7'b1000010: d.value = 4'hD;
            7'b0110000: d.value = 4'hE;
            7'b0111000: d.value = 4'hF;
`endif
            default:    d.kind  = SEG_ILLEGAL;
        endcase
        return d;
    endfunction

    // Registered copies of the bus and their values one cycle earlier.
    logic [6:0]            r_seg_q;
    logic [NUM_DIGITS-1:0] r_an_q;
    logic [6:0]            r_seg_prev;
    logic [NUM_DIGITS-1:0] r_an_prev;

    state_t                r_state;
    logic [SET_W-1:0]      r_settle_cnt;

    // Per-digit candidate value and run length of identical decodes.
    logic [3:0]            r_cand [NUM_DIGITS];
    logic [STB_W-1:0]      r_cnt  [NUM_DIGITS];

    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic                    r_frame_done;
    logic                    r_pattern_err;
    logic [NUM_DIGITS-1:0]   r_err_digit;

    logic [IDX_W-1:0]      w_sel;
    logic                  w_one_hot;
    logic                  w_stable;
    seg_dec_t              w_dec;
    logic [STB_W-1:0]      w_cnt_cur;
    logic [STB_W-1:0]      w_cnt_next;
    logic [3:0]            w_cand_cur;
    logic                  w_commit;
    logic [NUM_DIGITS-1:0] w_valid_next;

    // The bus is idle (no anode, blank segments) out of reset, so the first
    // real anode selection is seen as a change.
    // NOTE: state registers are written with <= so every flop samples the
    // pre-edge values; blocking writes here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_q    <= '1;
            r_an_q     <= '1;
            r_seg_prev <= '1;
            r_an_prev  <= '1;
        end else begin
            r_seg_q    <= seg_in;
            r_an_q     <= an_in;
            r_seg_prev <= r_seg_q;
            r_an_prev  <= r_an_q;
        end
    end

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_an_q[i]) begin
                w_sel = IDX_W'(i);
            end
        end
        w_one_hot    = ($countones(~r_an_q) == 1);
        w_stable     = (r_an_q == r_an_prev) && (r_seg_q == r_seg_prev);
        w_dec        = decode_seg(r_seg_q);
        w_cnt_cur    = r_cnt[w_sel];
        w_cand_cur   = r_cand[w_sel];
        w_cnt_next   = '0;
        w_commit     = 1'b0;
        w_valid_next = r_valid;

        case (w_dec.kind)
            SEG_NUM: begin
                if (w_dec.value == w_cand_cur) begin
                    w_cnt_next = (w_cnt_cur == STABLE_MAX) ? STABLE_MAX
                                                           : w_cnt_cur + 1'b1;
                end else begin
                    // A new value restarts the run; it is already the first
                    // sighting, so the count starts at one, not zero.
                    w_cnt_next = STABLE_ONE;
                end
                w_commit = (w_cnt_next == STABLE_MAX);
                if (w_commit) begin
                    w_valid_next[w_sel] = 1'b1;
                end
            end
            default: begin
                // Blank and illegal both invalidate the digit and clear its run.
                w_valid_next[w_sel] = 1'b0;
            end
        endcase
    end

    // NOTE: the per-digit candidate/count arrays are small flop arrays, not a
    // RAM, so they are reset along with everything else to drop partial runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_settle_cnt  <= '0;
            r_bcd         <= '0;
            r_valid       <= '0;
            r_frame_done  <= 1'b0;
            r_pattern_err <= 1'b0;
            r_err_digit   <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_cand[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_frame_done  <= 1'b0;
            r_pattern_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_one_hot) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end
                end

                ST_SETTLE: begin
                    if (!w_one_hot) begin
                        r_state <= ST_IDLE;
                    end else if (!w_stable) begin
                        r_settle_cnt <= '0;
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    // The bus may move on in the very cycle the sample is
                    // taken; such a dwell was too short and is discarded.
                    if (!w_one_hot) begin
                        r_state <= ST_IDLE;
                    end else if (!w_stable) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end else begin
                        r_state       <= ST_HOLD;
                        r_cnt[w_sel]  <= w_cnt_next;
                        r_valid       <= w_valid_next;
                        r_frame_done  <= (w_sel == LAST_IDX) && (&w_valid_next);
                        if (w_dec.kind == SEG_NUM) begin
                            r_cand[w_sel] <= w_dec.value;
                        end
                        if (w_commit) begin
                            r_bcd[4*w_sel +: 4] <= w_dec.value;
                        end
                        if (w_dec.kind == SEG_ILLEGAL) begin
                            r_pattern_err <= 1'b1;
                            r_err_digit   <= ONE_HOT_0 << w_sel;
                        end
                    end
                end

                ST_HOLD: begin
                    // One sample per dwell; a segment refresh under the same
                    // anode re-arms the settle window.
                    if (!w_one_hot) begin
                        r_state <= ST_IDLE;
                    end else if (!w_stable) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd_out     = r_bcd;
    assign digit_valid = r_valid;
    assign frame_done  = r_frame_done;
    assign pattern_err = r_pattern_err;
    assign err_digit   = r_err_digit;

endmodule
